// File: rtl/alu_flags_seq.sv
// Registered ALU with ARM-style NZCV flags and valid/ready handshakes.
// Single-cycle ops (ADD/SUB/XOR/NOT/AND/ORR/MOV) return one cycle after
// acceptance. MUL is a shift-add unit that retires one multiplier bit per
// cycle and completes N cycles after acceptance.
module alu_flags_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  input  logic         set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_ORR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic           accept_s;
  logic           mul_done_s;

  // single-cycle datapath
  logic [N-1:0]   b_op_s;
  logic           cin_s;
  logic [N:0]     sum_s;
  logic [N-1:0]   alu_res_s;
  logic           alu_cv_s;
  logic           alu_c_s;
  logic           alu_v_s;

  // multiplier state: multiplicand shifts left, multiplier shifts right
  logic [N-1:0]   mcand_r;
  logic [N-1:0]   mplier_r;
  logic [N-1:0]   acc_r;
  logic [N-1:0]   acc_nx_s;
  logic [CW-1:0]  cnt_r;
  logic           mul_setf_r;

  // output load selection
  logic           load_s;
  logic [N-1:0]   load_res_s;
  logic           load_setf_s;
  logic           load_cv_s;
  logic [3:0]     flags_nx_s;

  // The output slot may refill on the same edge it drains, so ready looks at out_ready.
  assign in_ready = (state_r == IDLE) && (!out_valid || out_ready);

  // Single-cycle ALU: shared N+1-bit adder gives the carry for ADD and SUB.
  always_comb begin
    b_op_s    = B;
    cin_s     = 1'b0;
    alu_res_s = {N{1'b0}};
    alu_cv_s  = 1'b0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    if (ALUControl == OP_SUB) begin
      b_op_s = ~B;
      cin_s  = 1'b1;
    end else begin
      b_op_s = B;
      cin_s  = 1'b0;
    end
    sum_s = {1'b0, A} + {1'b0, b_op_s} + {{N{1'b0}}, cin_s};
    case (ALUControl)
      OP_ADD: begin
        alu_res_s = sum_s[N-1:0];
        alu_cv_s  = 1'b1;
        alu_c_s   = sum_s[N];
        alu_v_s   = (A[N-1] == B[N-1]) && (sum_s[N-1] != A[N-1]);
      end
      OP_SUB: begin
        alu_res_s = sum_s[N-1:0];
        alu_cv_s  = 1'b1;
        alu_c_s   = sum_s[N];
        alu_v_s   = (A[N-1] != B[N-1]) && (sum_s[N-1] != A[N-1]);
      end
      OP_XOR:  alu_res_s = A ^ B;
      OP_NOT:  alu_res_s = ~B;
      OP_AND:  alu_res_s = A & B;
      OP_ORR:  alu_res_s = A | B;
      OP_MOV:  alu_res_s = B;
      OP_MUL:  alu_res_s = {N{1'b0}};
      default: alu_res_s = {N{1'b0}};
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) begin
      acc_nx_s = acc_r + mcand_r;
    end else begin
      acc_nx_s = acc_r;
    end
  end

  // Next-state logic: MUL runs for exactly N cycles, one bit per cycle.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = in_valid && in_ready;
    mul_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (ALUControl == OP_MUL)) begin
          state_nx_s = MUL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == LAST_BIT) begin
          state_nx_s = IDLE;
          mul_done_s = 1'b1;
        end else begin
          state_nx_s = MUL;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Pick what loads into the output register; C and V only change for ADD/SUB.
  always_comb begin
    load_s      = 1'b0;
    load_res_s  = alu_res_s;
    load_setf_s = set_flags;
    load_cv_s   = alu_cv_s;
    if (mul_done_s) begin
      load_s      = 1'b1;
      load_res_s  = acc_nx_s;
      load_setf_s = mul_setf_r;
      load_cv_s   = 1'b0;
    end else if (accept_s && (ALUControl != OP_MUL)) begin
      load_s      = 1'b1;
      load_res_s  = alu_res_s;
      load_setf_s = set_flags;
      load_cv_s   = alu_cv_s;
    end else begin
      load_s = 1'b0;
    end
    flags_nx_s = {load_res_s[N-1],
                  (load_res_s == {N{1'b0}}),
                  (load_cv_s ? alu_c_s : flags[1]),
                  (load_cv_s ? alu_v_s : flags[0])};
  end

  // State register and busy indicator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s == MUL);
    end
  end

  // Output register: load a finished op, otherwise drain on out_ready, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= {N{1'b0}};
      flags     <= 4'b0000;
    end else begin
      if (load_s) begin
        out_valid <= 1'b1;
        result    <= load_res_s;
        if (load_setf_s) begin
          flags <= flags_nx_s;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Multiplier registers: latch operands on acceptance, then shift each cycle in MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r    <= {N{1'b0}};
      mplier_r   <= {N{1'b0}};
      acc_r      <= {N{1'b0}};
      cnt_r      <= {CW{1'b0}};
      mul_setf_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && accept_s && (ALUControl == OP_MUL)) begin
        mcand_r    <= A;
        mplier_r   <= B;
        acc_r      <= {N{1'b0}};
        cnt_r      <= {CW{1'b0}};
        mul_setf_r <= set_flags;
      end else if (state_r == MUL) begin
        mcand_r  <= {mcand_r[N-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[N-1:1]};
        acc_r    <= acc_nx_s;
        cnt_r    <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule
